spart: RTL and testbench

Special-purpose asynchronous receiver/transmitter sitting directly below the bus-master driver FSM: it decodes the driver's chip-select/read-write/address bus cycles, holds a programmable 16-bit baud divisor, serialises written bytes onto `txd` and deserialises `rxd` into a receive buffer. Its `rda`/`tbr` flags are the driver's only flow-control inputs; the board UART pins connect to `txd`/`rxd`.

---
 rtl/spart.sv | 197 +++++++++++++++++++
 tb/tb_spart.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spart.sv
// rtl/spart.sv - special-purpose UART: bus-decoded registers, baud generator, TX/RX FSMs
module spart #(
  parameter logic [15:0] DEFAULT_DIV = 16'd325
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       iocs,
  input  logic       iorw,
  input  logic [1:0] ioaddr,
  inout  wire  [7:0] databus,
  output logic       rda,
  output logic       tbr,
  output logic       txd,
  input  logic       rxd
);
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  localparam logic [15:0] RST_CNT = (DEFAULT_DIV == 16'd0) ? 16'd1 : DEFAULT_DIV;

  logic wr, rd;
  assign wr = iocs & ~iorw;
  assign rd = iocs & iorw;

  // Baud generator: reload uses the post-write divisor so a write restarts cleanly.
  logic [15:0] divisor, div_next, reload, baud_cnt;
  logic        div_wr, en;
  assign div_wr = wr & ioaddr[1];
  assign en     = (baud_cnt == 16'd1);
  assign reload = (div_next == 16'd0) ? 16'd1 : div_next;

  always_comb begin
    div_next = divisor;
    if (div_wr) begin
      if (ioaddr[0]) div_next[15:8] = databus;
      else           div_next[7:0]  = databus;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      divisor  <= DEFAULT_DIV;
      baud_cnt <= RST_CNT;
    end else begin
      divisor <= div_next;
      if (div_wr || en) baud_cnt <= reload;
      else              baud_cnt <= baud_cnt - 16'd1;
    end
  end

  state_t      tx_state, tx_next;
  logic [3:0]  tx_en_cnt;
  logic [2:0]  tx_idx;
  logic [7:0]  tx_shreg;
  logic        tx_tick, tx_load;
  assign tx_tick = en && (tx_en_cnt == 4'd15);
  assign tx_load = wr && (ioaddr == 2'b00) && (tx_state == S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tx_state <= S_IDLE;
    else        tx_state <= tx_next;
  end

  always_comb begin
    tx_next = tx_state;
    tbr     = 1'b0;
    txd     = 1'b1;
    case (tx_state)
      S_IDLE: begin
        tbr = 1'b1;
        if (tx_load) tx_next = S_START;
      end
      S_START: begin
        txd = 1'b0;
        if (tx_tick) tx_next = S_DATA;
      end
      S_DATA: begin
        txd = tx_shreg[0];
        if (tx_tick && tx_idx == 3'd7) tx_next = S_STOP;
      end
      S_STOP: begin
        if (tx_tick) tx_next = S_IDLE;
      end
      default: tx_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_en_cnt <= 4'd0;
      tx_idx    <= 3'd0;
      tx_shreg  <= 8'd0;
    end else if (tx_load) begin
      tx_en_cnt <= 4'd0;
      tx_idx    <= 3'd0;
      tx_shreg  <= databus;
    end else if (tx_state != S_IDLE && en) begin
      tx_en_cnt <= tx_en_cnt + 4'd1;
      if (tx_tick && tx_state == S_DATA) begin
        tx_shreg <= {1'b0, tx_shreg[7:1]};
        tx_idx   <= tx_idx + 3'd1;
      end
    end
  end

  logic rx_s1, rx_s2, rx_prev, rx_fall;
  assign rx_fall = rx_prev & ~rx_s2;

  state_t      rx_state, rx_next;
  logic [3:0]  rx_en_cnt;
  logic [2:0]  rx_idx;
  logic [7:0]  rx_shreg, rx_buf;
  logic        rx_mid, rx_tick, rx_done;
  logic        ovr, ferr;
  assign rx_mid  = en && (rx_en_cnt == 4'd7);
  assign rx_tick = en && (rx_en_cnt == 4'd15);
  assign rx_done = (rx_state == S_STOP) && rx_tick;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rx_state <= S_IDLE;
    else        rx_state <= rx_next;
  end

  // START re-checks the line mid-bit; a high sample means the edge was a glitch.
  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      S_IDLE:  if (rx_fall) rx_next = S_START;
      S_START: if (rx_mid) rx_next = rx_s2 ? S_IDLE : S_DATA;
      S_DATA:  if (rx_tick && rx_idx == 3'd7) rx_next = S_STOP;
      S_STOP:  if (rx_tick) rx_next = S_IDLE;
      default: rx_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1     <= 1'b1;
      rx_s2     <= 1'b1;
      rx_prev   <= 1'b1;
      rx_en_cnt <= 4'd0;
      rx_idx    <= 3'd0;
      rx_shreg  <= 8'd0;
    end else begin
      rx_s1   <= rxd;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
      if (rx_state == S_IDLE) begin
        rx_en_cnt <= 4'd0;
        rx_idx    <= 3'd0;
      end else if (rx_state == S_START && rx_mid) begin
        rx_en_cnt <= 4'd0;
      end else if (en) begin
        rx_en_cnt <= rx_en_cnt + 4'd1;
        if (rx_tick && rx_state == S_DATA) begin
          rx_shreg <= {rx_s2, rx_shreg[7:1]};
          rx_idx   <= rx_idx + 3'd1;
        end
      end
    end
  end

  // Flag sets take priority over read-side clears in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_buf <= 8'd0;
      rda    <= 1'b0;
      ovr    <= 1'b0;
      ferr   <= 1'b0;
    end else begin
      if (rx_done && rx_s2) begin
        rx_buf <= rx_shreg;
        rda    <= 1'b1;
      end else if (rd && ioaddr == 2'b00) begin
        rda <= 1'b0;
      end
      if (rx_done && rx_s2 && rda)        ovr <= 1'b1;
      else if (rd && ioaddr == 2'b01)     ovr <= 1'b0;
      if (rx_done && !rx_s2)              ferr <= 1'b1;
      else if (rd && ioaddr == 2'b01)     ferr <= 1'b0;
    end
  end

  logic [7:0] rdata;
  always_comb begin
    rdata = 8'd0;
    case (ioaddr)
      2'b00: rdata = rx_buf;
      2'b01: rdata = {4'b0000, ovr, ferr, tbr, rda};
      2'b10: rdata = divisor[7:0];
      2'b11: rdata = divisor[15:8];
      default: rdata = 8'd0;
    endcase
  end

  assign databus = rd ? rdata : 8'bz;

endmodule

// File: tb/tb_spart.sv
// tb/tb_spart.sv - scoreboard bench for spart: register access, TX frames, RX frames and flags
module tb_spart;
  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       iocs = 1'b0;
  logic       iorw = 1'b0;
  logic [1:0] ioaddr = 2'b00;
  logic       rxd = 1'b1;
  logic       drv_en = 1'b0;
  logic [7:0] drv_val = 8'h00;
  wire  [7:0] databus;
  logic       rda, tbr, txd;

  assign databus = drv_en ? drv_val : 8'bz;

  spart dut (
    .clk(clk), .rst_n(rst_n), .iocs(iocs), .iorw(iorw), .ioaddr(ioaddr),
    .databus(databus), .rda(rda), .tbr(tbr), .txd(txd), .rxd(rxd)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;
  int div_now = 4;
  bit mon_en = 1'b0;
  int frames = 0;
  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];
  logic m_rda = 1'b0, m_ovr = 1'b0, m_ferr = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] pop_rx();
    if (rx_q.size() == 0) return 8'h00;
    return rx_q.pop_front();
  endfunction

  task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    iocs = 1'b1; iorw = 1'b0; ioaddr = a; drv_en = 1'b1; drv_val = d;
    @(negedge clk);
    iocs = 1'b0; drv_en = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
    @(negedge clk);
    iocs = 1'b1; iorw = 1'b1; ioaddr = a;
    #1 d = databus;
    @(negedge clk);
    iocs = 1'b0; iorw = 1'b0;
  endtask

  task automatic read_status();
    logic [7:0] d;
    bus_read(2'b01, d);
    check("status", d, {4'b0000, m_ovr, m_ferr, 1'b1, m_rda});
    m_ovr = 1'b0;
    m_ferr = 1'b0;
  endtask

  task automatic read_rx();
    logic [7:0] d;
    check("rda_before_read", rda, m_rda);
    bus_read(2'b00, d);
    check("rx_data", d, pop_rx());
    m_rda = 1'b0;
    check("rda_after_read", rda, 1'b0);
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop_bit);
    logic [9:0] bits;
    if (stop_bit) begin
      if (m_rda) begin
        void'(rx_q.pop_front());
        m_ovr = 1'b1;
      end
      rx_q.push_back(b);
      m_rda = 1'b1;
    end else begin
      m_ferr = 1'b1;
    end
    bits = {stop_bit, b, 1'b0};
    @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      rxd = bits[k];
      repeat (16 * div_now) @(negedge clk);
    end
    rxd = 1'b1;
  endtask

  task automatic wait_tx_done(input bit poke, output int n);
    n = 1;
    while (!tbr && n < 2000) begin
      @(negedge clk);
      if (!tbr) n++;
      if (poke && n == 300) begin
        iocs = 1'b1; iorw = 1'b0; ioaddr = 2'b00; drv_en = 1'b1; drv_val = 8'h0F;
      end else if (iocs && !iorw) begin
        iocs = 1'b0; drv_en = 1'b0;
      end
    end
    check("tbr_returned", tbr, 1'b1);
  endtask

  // TX monitor: decode each frame at mid-bit points and check edge spacing.
  initial begin : tx_mon
    logic prev, stopv;
    int s, d;
    logic [7:0] got, exp;
    logic [9:0] x;
    logic last;
    int t[$];
    int bq[$];
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (mon_en && rst_n && prev && !txd) begin
        s = cyc; d = div_now; t.delete(); bq.delete(); last = 1'b0; got = 8'h00; stopv = 1'b0;
        while (cyc - s < 156 * d) begin
          @(negedge clk);
          if (txd !== last) begin
            t.push_back(cyc);
            last = txd;
          end
          for (int i = 0; i < 8; i++)
            if (cyc - s == 16 * d * (i + 1) + 7 * d) got[i] = txd;
          if (cyc - s == 16 * d * 9 + 7 * d) stopv = txd;
        end
        frames++;
        check("tx_pending", tx_q.size(), 1);
        if (tx_q.size() != 0) begin
          exp = tx_q.pop_front();
          check("tx_byte", got, exp);
          check("tx_stop", stopv, 1'b1);
          x = {1'b1, exp, 1'b0};
          for (int k = 1; k < 10; k++) if (x[k] != x[k-1]) bq.push_back(k);
          check("tx_edge_count", t.size(), bq.size());
          if (t.size() > 0 && bq.size() > 0) begin
            check("tx_start_len", ((t[0] - s - (bq[0] - 1) * 16 * d) >= 15 * d + 1) &&
                                  ((t[0] - s - (bq[0] - 1) * 16 * d) <= 16 * d), 1);
            for (int j = 1; j < t.size() && j < bq.size(); j++)
              check("tx_bit_len", t[j] - t[0], (bq[j] - bq[0]) * 16 * d);
          end
        end
      end
      prev = txd;
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [7:0] d;
    int n;
    bit seen;

    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check("rst_txd", txd, 1'b1);
    check("rst_tbr", tbr, 1'b1);
    check("rst_rda", rda, 1'b0);
    drv_en = 1'b1; drv_val = 8'h5A;
    #1 check("rst_bus_released", databus, 8'h5A);
    drv_en = 1'b0;
    bus_read(2'b10, d); check("rst_div_lo", d, 8'h45);
    bus_read(2'b11, d); check("rst_div_hi", d, 8'h01);
    bus_read(2'b00, d); check("rst_rxbuf", d, 8'h00);
    read_status();

    bus_write(2'b00, 8'h77);
    check("busy_tbr", tbr, 1'b0);
    check("busy_txd", txd, 1'b0);
    repeat (50) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_txd", txd, 1'b1);
    check("async_rst_tbr", tbr, 1'b1);
    check("async_rst_rda", rda, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    bus_read(2'b10, d); check("rst2_div_lo", d, 8'h45);

    bus_write(2'b10, 8'h04);
    bus_write(2'b11, 8'h00);
    div_now = 4;
    mon_en = 1'b1;
    bus_read(2'b10, d); check("div_lo_rb", d, 8'h04);
    bus_read(2'b11, d); check("div_hi_rb", d, 8'h00);
    tx_q.push_back(8'hA5);
    bus_write(2'b00, 8'hA5);
    check("tx_start_tbr", tbr, 1'b0);
    check("tx_start_txd", txd, 1'b0);
    wait_tx_done(1'b1, n);
    check("tx_tbr_low_len", (n >= 637) && (n <= 640), 1);
    repeat (200) @(negedge clk);
    check("tx_frames_a5", frames, 1);
    check("tx_q_drained", tx_q.size(), 0);

    send_rx(8'h3C, 1'b1);
    read_rx();

    @(negedge clk); rxd = 1'b0;
    repeat (10) @(negedge clk);
    rxd = 1'b1;
    repeat (100) @(negedge clk);
    check("glitch_no_rda", rda, 1'b0);
    read_status();

    send_rx(8'h55, 1'b0);
    repeat (20) @(negedge clk);
    check("ferr_no_rda", rda, 1'b0);
    read_status();
    read_status();

    send_rx(8'h11, 1'b1);
    send_rx(8'h22, 1'b1);
    read_rx();
    read_status();

    @(negedge clk);
    iocs = 1'b1; iorw = 1'b1; ioaddr = 2'b00;
    seen = 1'b0;
    fork
      send_rx(8'h6B, 1'b1);
      begin
        for (int i = 0; i < 800 && !seen; i++) begin
          @(negedge clk);
          if (rda) begin
            seen = 1'b1;
            d = databus;
          end
        end
        check("rda_set_wins", seen, 1'b1);
        if (seen) begin
          check("held_read_data", d, pop_rx());
          @(negedge clk);
          check("held_read_clears", rda, 1'b0);
        end
      end
    join
    iocs = 1'b0; iorw = 1'b0;
    m_rda = 1'b0;
    read_status();

    bus_write(2'b10, 8'h00);
    bus_write(2'b11, 8'h00);
    div_now = 1;
    tx_q.push_back(8'h3C);
    bus_write(2'b00, 8'h3C);
    check("div0_tbr", tbr, 1'b0);
    wait_tx_done(1'b0, n);
    check("div0_frame_len", n, 160);
    repeat (50) @(negedge clk);
    check("tx_frames_total", frames, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
